// File: rtl/rv32i_pkg.sv
// Shared RV32I encoder definitions: formats, reused opcodes and range helpers.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_LI = 3'd6
  } enc_fmt_t;

  localparam logic [6:0] OPCODE_LUI        = 7'h37;
  localparam logic [6:0] OPCODE_I_TYPE_ALU = 7'h13;
  localparam logic [2:0] FUNCT3_ADDI       = 3'b000;

  // True when v survives truncation to a bits-wide two's-complement field.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int bits);
    logic [XLEN-1:0] sh;
    sh = $signed(v) >>> (bits - 1);
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: scatters the immediate per format and flags
// immediates that the chosen format cannot represent.
module instr_pack
  import rv32i_pkg::*;
(
  input  enc_fmt_t         fmt_in,
  input  logic [6:0]       opcode_in,
  input  logic [2:0]       funct3_in,
  input  logic [6:0]       funct7_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       rs1_in,
  input  logic [4:0]       rs2_in,
  input  logic [XLEN-1:0]  imm_in,
  output logic [ILEN-1:0]  instr_out,
  output logic             err_out
);

  always_comb begin
    instr_out = '0;
    err_out   = 1'b0;
    unique case (fmt_in)
      FMT_R: begin
        instr_out = {funct7_in, rs2_in, rs1_in, funct3_in, rd_in, opcode_in};
      end
      FMT_I: begin
        instr_out = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
        err_out   = !fits_signed(imm_in, 12);
      end
      FMT_S: begin
        instr_out = {imm_in[11:5], rs2_in, rs1_in, funct3_in, imm_in[4:0], opcode_in};
        err_out   = !fits_signed(imm_in, 12);
      end
      FMT_B: begin
        instr_out = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, funct3_in,
                     imm_in[4:1], imm_in[11], opcode_in};
        err_out   = !fits_signed(imm_in, 13) || imm_in[0];
      end
      FMT_U: begin
        instr_out = {imm_in[31:12], rd_in, opcode_in};
        err_out   = (imm_in[11:0] != 12'd0);
      end
      FMT_J: begin
        instr_out = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, opcode_in};
        err_out   = !fits_signed(imm_in, 21) || imm_in[0];
      end
      default: begin
        // LI is rewritten into I/U fields by the caller and never reaches here.
        instr_out = '0;
        err_out   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder for the debug injector: one registered output beat,
// with LI expanded into LUI+ADDI when the constant does not fit 12 bits.
module instr_encoder
  import rv32i_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [2:0]       req_fmt_in,
  input  logic [6:0]       req_opcode_in,
  input  logic [2:0]       req_funct3_in,
  input  logic [6:0]       req_funct7_in,
  input  logic [4:0]       req_rd_in,
  input  logic [4:0]       req_rs1_in,
  input  logic [4:0]       req_rs2_in,
  input  logic [XLEN-1:0]  req_imm_in,
  output logic             instr_valid_out,
  input  logic             instr_ready_in,
  output logic [ILEN-1:0]  instr_out,
  output logic             instr_err_out,
  output logic             instr_last_out
);

  typedef enum logic [1:0] {IDLE, OUT_HI, OUT_LAST} state_t;

  state_t            state_q, state_d;
  logic [ILEN-1:0]   instr_q, instr_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic [4:0]        lo_rd_q, lo_rd_d;
  logic [11:0]       lo_imm_q, lo_imm_d;

  enc_fmt_t          req_fmt;
  logic              li_req, li_small, accept;
  logic [19:0]       li_hi;

  enc_fmt_t          p_fmt;
  logic [6:0]        p_opcode, p_funct7;
  logic [2:0]        p_funct3;
  logic [4:0]        p_rd, p_rs1, p_rs2;
  logic [XLEN-1:0]   p_imm;
  logic [ILEN-1:0]   p_instr;
  logic              p_err;

  assign req_fmt  = enc_fmt_t'(req_fmt_in);
  assign li_req   = (req_fmt == FMT_LI);
  assign li_small = fits_signed(req_imm_in, 12);
  // Rounding the upper part up when bit 11 is set compensates for ADDI sign-extension.
  assign li_hi    = req_imm_in[31:12] + {19'd0, req_imm_in[11]};

  assign req_ready_out   = (state_q == IDLE) || ((state_q == OUT_LAST) && instr_ready_in);
  assign accept          = req_valid_in && req_ready_out;
  assign instr_valid_out = (state_q != IDLE);
  assign instr_out       = instr_q;
  assign instr_err_out   = err_q;
  assign instr_last_out  = last_q;

  always_comb begin
    p_fmt    = req_fmt;
    p_opcode = req_opcode_in;
    p_funct3 = req_funct3_in;
    p_funct7 = req_funct7_in;
    p_rd     = req_rd_in;
    p_rs1    = req_rs1_in;
    p_rs2    = req_rs2_in;
    p_imm    = req_imm_in;
    if (state_q == OUT_HI) begin
      p_fmt    = FMT_I;
      p_opcode = OPCODE_I_TYPE_ALU;
      p_funct3 = FUNCT3_ADDI;
      p_funct7 = '0;
      p_rd     = lo_rd_q;
      p_rs1    = lo_rd_q;
      p_rs2    = '0;
      p_imm    = {{(XLEN-12){lo_imm_q[11]}}, lo_imm_q};
    end else if (li_req) begin
      p_funct7 = '0;
      p_rs1    = '0;
      p_rs2    = '0;
      p_funct3 = FUNCT3_ADDI;
      if (li_small) begin
        p_fmt    = FMT_I;
        p_opcode = OPCODE_I_TYPE_ALU;
      end else begin
        p_fmt    = FMT_U;
        p_opcode = OPCODE_LUI;
        p_imm    = {li_hi, 12'd0};
      end
    end
  end

  instr_pack u_pack (
    .fmt_in    (p_fmt),
    .opcode_in (p_opcode),
    .funct3_in (p_funct3),
    .funct7_in (p_funct7),
    .rd_in     (p_rd),
    .rs1_in    (p_rs1),
    .rs2_in    (p_rs2),
    .imm_in    (p_imm),
    .instr_out (p_instr),
    .err_out   (p_err)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    err_d    = err_q;
    last_d   = last_q;
    lo_rd_d  = lo_rd_q;
    lo_imm_d = lo_imm_q;
    if (state_q == OUT_HI) begin
      if (instr_ready_in) begin
        state_d = OUT_LAST;
        instr_d = p_instr;
        err_d   = p_err;
        last_d  = 1'b1;
      end
    end else if (accept) begin
      instr_d  = p_instr;
      err_d    = p_err;
      lo_rd_d  = req_rd_in;
      lo_imm_d = req_imm_in[11:0];
      if (li_req && !li_small) begin
        state_d = OUT_HI;
        last_d  = 1'b0;
      end else begin
        state_d = OUT_LAST;
        last_d  = 1'b1;
      end
    end else if ((state_q == OUT_LAST) && instr_ready_in) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      lo_rd_q  <= '0;
      lo_imm_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
      last_q   <= last_d;
      lo_rd_q  <= lo_rd_d;
      lo_imm_q <= lo_imm_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-encoded RV32I words.
module tb_instr_encoder;

  logic        clk_in;
  logic        rst_n_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [2:0]  req_fmt_in;
  logic [6:0]  req_opcode_in;
  logic [2:0]  req_funct3_in;
  logic [6:0]  req_funct7_in;
  logic [4:0]  req_rd_in;
  logic [4:0]  req_rs1_in;
  logic [4:0]  req_rs2_in;
  logic [31:0] req_imm_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic        instr_err_out;
  logic        instr_last_out;

  int tests;
  int failures;

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_LI = 3'd6;

  instr_encoder dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .req_fmt_in      (req_fmt_in),
    .req_opcode_in   (req_opcode_in),
    .req_funct3_in   (req_funct3_in),
    .req_funct7_in   (req_funct7_in),
    .req_rd_in       (req_rd_in),
    .req_rs1_in      (req_rs1_in),
    .req_rs2_in      (req_rs2_in),
    .req_imm_in      (req_imm_in),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in),
    .instr_out       (instr_out),
    .instr_err_out   (instr_err_out),
    .instr_last_out  (instr_last_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    req_fmt_in    = fmt;
    req_opcode_in = opc;
    req_funct3_in = f3;
    req_funct7_in = f7;
    req_rd_in     = rd;
    req_rs1_in    = rs1;
    req_rs2_in    = rs2;
    req_imm_in    = imm;
    req_valid_in  = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in       = 1'b0;
    req_valid_in   = 1'b0;
    instr_ready_in = 1'b1;
    set_req(F_R, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    req_valid_in = 1'b0;
    #12;
    tests++;
    if ({instr_valid_out, instr_out, instr_err_out, instr_last_out} !== 35'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got v=%b i=%h e=%b l=%b expected all zero",
               instr_valid_out, instr_out, instr_err_out, instr_last_out);
    end
    tests++;
    if (req_ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_out);
    end
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    next_cycle();
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  task automatic test_formats();
    vec_t v[14];
    v[0]  = '{F_I, 7'h13, 3'h0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0};
    v[1]  = '{F_I, 7'h13, 3'h0, 7'h00, 5'd1, 5'd2, 5'd0, 32'h00000800, 32'h80010093, 1'b1};
    v[2]  = '{F_I, 7'h13, 3'h0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFF800, 32'h80010093, 1'b0};
    v[3]  = '{F_S, 7'h23, 3'h2, 7'h00, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC, 32'hFE512E23, 1'b0};
    v[4]  = '{F_B, 7'h63, 3'h0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0};
    v[5]  = '{F_B, 7'h63, 3'h0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h00000003, 32'h00208163, 1'b1};
    v[6]  = '{F_B, 7'h63, 3'h0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h00001000, 32'h80208063, 1'b1};
    v[7]  = '{F_U, 7'h37, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0};
    v[8]  = '{F_U, 7'h37, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h12345001, 32'h123450B7, 1'b1};
    v[9]  = '{F_R, 7'h33, 3'h0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h00000000, 32'h002081B3, 1'b0};
    v[10] = '{F_R, 7'h33, 3'h0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hFFFFFFFF, 32'h402081B3, 1'b0};
    v[11] = '{F_J, 7'h6F, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0};
    v[12] = '{F_J, 7'h6F, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000001, 32'h000000EF, 1'b1};
    v[13] = '{F_J, 7'h6F, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h800000EF, 1'b1};
    instr_ready_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_req(v[i].fmt, v[i].opc, v[i].f3, v[i].f7, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      tests++;
      if (req_ready_out !== 1'b1) begin
        failures++;
        $display("[TB] FAIL fmt%0d_ready: got %b expected 1", i, req_ready_out);
      end
      next_cycle();
      req_valid_in = 1'b0;
      tests++;
      if (instr_valid_out !== 1'b1 || instr_out !== v[i].exp_instr ||
          instr_err_out !== v[i].exp_err || instr_last_out !== 1'b1) begin
        failures++;
        $display("[TB] FAIL fmt%0d_beat: got v=%b i=%h e=%b l=%b expected v=1 i=%h e=%b l=1",
                 i, instr_valid_out, instr_out, instr_err_out, instr_last_out,
                 v[i].exp_instr, v[i].exp_err);
      end
      next_cycle();
      tests++;
      if (instr_valid_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL fmt%0d_drain: got valid %b expected 0", i, instr_valid_out);
      end
    end
  endtask

  task automatic test_li();
    logic [4:0]  rd[5];
    logic [31:0] imm[5];
    logic        two[5];
    logic [31:0] e1[5];
    logic [31:0] e2[5];
    rd[0] = 5'd5; imm[0] = 32'h12345FFF; two[0] = 1'b1; e1[0] = 32'h123462B7; e2[0] = 32'hFFF28293;
    rd[1] = 5'd3; imm[1] = 32'hFFFFFFFB; two[1] = 1'b0; e1[1] = 32'hFFB00193; e2[1] = 32'h0;
    rd[2] = 5'd5; imm[2] = 32'h7FFFF800; two[2] = 1'b1; e1[2] = 32'h800002B7; e2[2] = 32'h80028293;
    rd[3] = 5'd5; imm[3] = 32'h00000800; two[3] = 1'b1; e1[3] = 32'h000012B7; e2[3] = 32'h80028293;
    rd[4] = 5'd5; imm[4] = 32'hFFFFF800; two[4] = 1'b0; e1[4] = 32'h80000293; e2[4] = 32'h0;
    instr_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      // opcode/funct/rs fields are junk on purpose: LI must ignore them
      set_req(F_LI, 7'h7F, 3'h7, 7'h7F, rd[i], 5'd7, 5'd9, imm[i]);
      next_cycle();
      req_valid_in = 1'b0;
      tests++;
      if (instr_valid_out !== 1'b1 || instr_out !== e1[i] || instr_err_out !== 1'b0 ||
          instr_last_out !== !two[i]) begin
        failures++;
        $display("[TB] FAIL li%0d_beat1: got v=%b i=%h e=%b l=%b expected v=1 i=%h e=0 l=%b",
                 i, instr_valid_out, instr_out, instr_err_out, instr_last_out, e1[i], !two[i]);
      end
      if (two[i]) begin
        tests++;
        if (req_ready_out !== 1'b0) begin
          failures++;
          $display("[TB] FAIL li%0d_ready_hi: got %b expected 0", i, req_ready_out);
        end
        next_cycle();
        tests++;
        if (instr_valid_out !== 1'b1 || instr_out !== e2[i] || instr_err_out !== 1'b0 ||
            instr_last_out !== 1'b1) begin
          failures++;
          $display("[TB] FAIL li%0d_beat2: got v=%b i=%h e=%b l=%b expected v=1 i=%h e=0 l=1",
                   i, instr_valid_out, instr_out, instr_err_out, instr_last_out, e2[i]);
        end
      end
      next_cycle();
      tests++;
      if (instr_valid_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL li%0d_drain: got valid %b expected 0", i, instr_valid_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    instr_ready_in = 1'b1;
    set_req(F_I, 7'h13, 3'h0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
    next_cycle();
    set_req(F_LI, 7'h00, 3'h0, 7'h00, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFB);
    tests++;
    if (instr_out !== 32'hFFF10093 || req_ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_first: got i=%h rdy=%b expected i=fff10093 rdy=1",
               instr_out, req_ready_out);
    end
    next_cycle();
    set_req(F_LI, 7'h00, 3'h0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    tests++;
    if (instr_valid_out !== 1'b1 || instr_out !== 32'hFFB00193 || instr_last_out !== 1'b1 ||
        req_ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_second: got v=%b i=%h l=%b rdy=%b expected v=1 i=ffb00193 l=1 rdy=1",
               instr_valid_out, instr_out, instr_last_out, req_ready_out);
    end
    next_cycle();
    req_valid_in = 1'b0;
    tests++;
    if (instr_out !== 32'h123462B7 || instr_last_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_third: got i=%h l=%b expected i=123462b7 l=0",
               instr_out, instr_last_out);
    end
    next_cycle();
    next_cycle();
    tests++;
    if (instr_valid_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got valid %b expected 0", instr_valid_out);
    end
  endtask

  task automatic test_stall();
    instr_ready_in = 1'b0;
    set_req(F_J, 7'h6F, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800);
    next_cycle();
    set_req(F_I, 7'h13, 3'h0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (instr_valid_out !== 1'b1 || instr_out !== 32'h001000EF || instr_err_out !== 1'b0 ||
          instr_last_out !== 1'b1 || req_ready_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d: got v=%b i=%h e=%b l=%b rdy=%b expected v=1 i=001000ef e=0 l=1 rdy=0",
                 i, instr_valid_out, instr_out, instr_err_out, instr_last_out, req_ready_out);
      end
      next_cycle();
    end
    instr_ready_in = 1'b1;
    #1;
    tests++;
    if (req_ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release_ready: got %b expected 1", req_ready_out);
    end
    next_cycle();
    req_valid_in = 1'b0;
    tests++;
    if (instr_valid_out !== 1'b1 || instr_out !== 32'hFFF10093) begin
      failures++;
      $display("[TB] FAIL stall_pending_req: got v=%b i=%h expected v=1 i=fff10093",
               instr_valid_out, instr_out);
    end
    next_cycle();
    tests++;
    if (instr_valid_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_drain: got valid %b expected 0", instr_valid_out);
    end
  endtask

  task automatic test_reset_mid_li();
    instr_ready_in = 1'b0;
    set_req(F_LI, 7'h00, 3'h0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    next_cycle();
    req_valid_in = 1'b0;
    tests++;
    if (instr_out !== 32'h123462B7 || instr_last_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstli_beat1: got i=%h l=%b expected i=123462b7 l=0",
               instr_out, instr_last_out);
    end
    #2 rst_n_in = 1'b0;
    #1;
    tests++;
    if ({instr_valid_out, instr_out, instr_err_out, instr_last_out} !== 35'd0) begin
      failures++;
      $display("[TB] FAIL rstli_async_clear: got v=%b i=%h e=%b l=%b expected all zero",
               instr_valid_out, instr_out, instr_err_out, instr_last_out);
    end
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    instr_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      tests++;
      if (instr_valid_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rstli_no_beat2_%0d: got valid %b i=%h expected valid 0",
                 i, instr_valid_out, instr_out);
      end
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    test_reset();
    test_formats();
    test_li();
    test_back_to_back();
    test_stall();
    test_reset_mid_li();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
